// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - EX-stage ALU operand/control sequencer with result valid/ready handshake
module alu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  output logic [31:0] ALUin1_o,
  output logic [31:0] ALUin2_o,
  output logic [2:0]  ALUCtrl_o,
  input  logic [31:0] ALUResult_i,
  output logic [31:0] result_o,
  output logic        illegal_o,
  output logic        result_valid_o,
  input  logic        result_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_SRAI = 3'b110;
  localparam logic [2:0] ALU_BAD  = 3'b111;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  // Extra EXEC cycles a mul spends before capture; counter holds the remaining count.
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] in1_q, in1_d;
  logic [31:0] in2_q, in2_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        flag_q, flag_d;
  logic [31:0] res_q, res_d;
  logic        ill_q, ill_d;
  logic        rv_q, rv_d;

  logic [2:0]  dec_ctrl;
  logic [31:0] dec_op2;
  logic        dec_illegal;
  logic        dec_mul;

  // Decode the incoming instruction fields into an ALU code and second operand.
  always_comb begin
    dec_ctrl    = ALU_BAD;
    dec_op2     = rs2_data_i;
    dec_illegal = 1'b1;
    dec_mul     = 1'b0;
    case (opcode_i)
      OP_REG: begin
        if (funct7_i == F7_BASE) begin
          case (funct3_i)
            3'b111:  begin dec_ctrl = ALU_AND; dec_illegal = 1'b0; end
            3'b100:  begin dec_ctrl = ALU_XOR; dec_illegal = 1'b0; end
            3'b000:  begin dec_ctrl = ALU_ADD; dec_illegal = 1'b0; end
            3'b001:  begin dec_ctrl = ALU_SLL; dec_illegal = 1'b0; end
            default: begin dec_ctrl = ALU_BAD; dec_illegal = 1'b1; end
          endcase
        end else if (funct7_i == F7_ALT && funct3_i == 3'b000) begin
          dec_ctrl    = ALU_SUB;
          dec_illegal = 1'b0;
        end else if (funct7_i == F7_MULD && funct3_i == 3'b000) begin
          dec_ctrl    = ALU_MUL;
          dec_illegal = 1'b0;
          dec_mul     = 1'b1;
        end
      end
      OP_IMM: begin
        if (funct3_i == 3'b000) begin
          dec_ctrl    = ALU_ADD;
          dec_op2     = imm_i;
          dec_illegal = 1'b0;
        end else if (funct3_i == 3'b101 && funct7_i == F7_ALT) begin
          dec_ctrl    = ALU_SRAI;
          dec_op2     = {27'b0, imm_i[4:0]};
          dec_illegal = 1'b0;
        end
      end
      OP_LOAD, OP_STORE: begin
        dec_ctrl    = ALU_ADD;
        dec_op2     = imm_i;
        dec_illegal = 1'b0;
      end
      OP_BRANCH: begin
        dec_ctrl    = ALU_SUB;
        dec_illegal = 1'b0;
      end
      default: begin
        dec_ctrl    = ALU_BAD;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Sequencer next state: accept in IDLE, count down in EXEC, hold until handshake in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    ctrl_d  = ctrl_q;
    flag_d  = flag_q;
    res_d   = res_q;
    ill_d   = ill_q;
    rv_d    = rv_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          in1_d   = rs1_data_i;
          in2_d   = dec_op2;
          ctrl_d  = dec_ctrl;
          flag_d  = dec_illegal;
          cnt_d   = dec_mul ? MUL_CNT : 4'd0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d   = ALUResult_i;
          ill_d   = flag_q;
          rv_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (result_ready_i) begin
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Flush discards whatever is in flight and blocks a same-cycle accept.
    if (flush_i) begin
      state_d = S_IDLE;
      rv_d    = 1'b0;
      ill_d   = 1'b0;
      ctrl_d  = ALU_BAD;
      cnt_d   = 4'd0;
      in1_d   = in1_q;
      in2_d   = in2_q;
      flag_d  = flag_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      in1_q   <= 32'd0;
      in2_q   <= 32'd0;
      ctrl_q  <= ALU_BAD;
      flag_q  <= 1'b0;
      res_q   <= 32'd0;
      ill_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      ctrl_q  <= ctrl_d;
      flag_q  <= flag_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
      rv_q    <= rv_d;
    end
  end

  assign ready_o        = (state_q == S_IDLE);
  assign ALUin1_o       = in1_q;
  assign ALUin2_o       = in2_q;
  assign ALUCtrl_o      = ctrl_q;
  assign result_o       = res_q;
  assign illegal_o      = ill_q;
  assign result_valid_o = rv_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic [31:0] ALUin1_o;
  logic [31:0] ALUin2_o;
  logic [2:0]  ALUCtrl_o;
  logic [31:0] ALUResult_i;
  logic [31:0] result_o;
  logic        illegal_o;
  logic        result_valid_o;
  logic        result_ready_i;

  int checks;
  int errors;

  alu_issue_ctrl #(.MUL_LAT(3)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .opcode_i       (opcode_i),
    .funct3_i       (funct3_i),
    .funct7_i       (funct7_i),
    .rs1_data_i     (rs1_data_i),
    .rs2_data_i     (rs2_data_i),
    .imm_i          (imm_i),
    .ALUin1_o       (ALUin1_o),
    .ALUin2_o       (ALUin2_o),
    .ALUCtrl_o      (ALUCtrl_o),
    .ALUResult_i    (ALUResult_i),
    .result_o       (result_o),
    .illegal_o      (illegal_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural ALU driven by the DUT's operand/control outputs.
  always_comb begin
    case (ALUCtrl_o)
      3'b000:  ALUResult_i = ALUin1_o & ALUin2_o;
      3'b001:  ALUResult_i = ALUin1_o ^ ALUin2_o;
      3'b010:  ALUResult_i = ALUin1_o + ALUin2_o;
      3'b011:  ALUResult_i = ALUin1_o - ALUin2_o;
      3'b100:  ALUResult_i = ALUin1_o << ALUin2_o[4:0];
      3'b101:  ALUResult_i = ALUin1_o * ALUin2_o;
      3'b110:  ALUResult_i = $unsigned($signed(ALUin1_o) >>> ALUin2_o[4:0]);
      default: ALUResult_i = 32'd0;
    endcase
  end

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    opcode_i   = op;
    funct3_i   = f3;
    funct7_i   = f7;
    rs1_data_i = a;
    rs2_data_i = b;
    imm_i      = im;
  endtask

  // Present an op for one edge (the accept edge); returns at the following negedge.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    set_op(op, f3, f7, a, b, im);
    valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic handshake();
    result_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    result_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", ready_o); end
    checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rv got %0b want 0", result_valid_o); end
    checks++; if (ALUCtrl_o !== 3'b111) begin errors++; $display("FAIL reset_ctrl got %b want 111", ALUCtrl_o); end
    checks++; if (result_o !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result_o); end
    checks++; if (ALUin1_o !== 32'd0 || ALUin2_o !== 32'd0) begin errors++; $display("FAIL reset_ops got %h/%h want 0/0", ALUin1_o, ALUin2_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_add();
    issue(7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd0);
    checks++; if (ALUCtrl_o !== 3'b010) begin errors++; $display("FAIL add_ctrl got %b want 010", ALUCtrl_o); end
    checks++; if (ready_o !== 1'b0 || result_valid_o !== 1'b0) begin errors++; $display("FAIL add_exec ready/rv got %0b/%0b want 0/0", ready_o, result_valid_o); end
    @(negedge clk_i);
    checks++; if (result_valid_o !== 1'b1 || result_o !== 32'd12) begin errors++; $display("FAIL add_result got rv=%0b %0d want rv=1 12", result_valid_o, result_o); end
    handshake();
    checks++; if (ready_o !== 1'b1 || result_valid_o !== 1'b0) begin errors++; $display("FAIL add_handshake ready/rv got %0b/%0b want 1/0", ready_o, result_valid_o); end
  endtask

  task automatic test_mul();
    issue(7'b0110011, 3'b000, 7'b0000001, 32'd6, 32'd7, 32'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ALUCtrl_o !== 3'b101 || ready_o !== 1'b0 || result_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL mul_hold cyc %0d got ctrl=%b ready=%0b rv=%0b want 101/0/0", i, ALUCtrl_o, ready_o, result_valid_o);
      end
      if (i < 2) @(negedge clk_i);
    end
    @(negedge clk_i);
    checks++; if (result_valid_o !== 1'b1 || result_o !== 32'd42 || ready_o !== 1'b0) begin errors++; $display("FAIL mul_result got rv=%0b %0d ready=%0b want rv=1 42 ready=0", result_valid_o, result_o, ready_o); end
    handshake();
  endtask

  task automatic test_srai();
    issue(7'b0010011, 3'b101, 7'b0100000, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_0404);
    checks++; if (ALUin2_o !== 32'd4 || ALUCtrl_o !== 3'b110) begin errors++; $display("FAIL srai_ops got in2=%h ctrl=%b want 4/110", ALUin2_o, ALUCtrl_o); end
    @(negedge clk_i);
    checks++; if (result_valid_o !== 1'b1 || result_o !== 32'hF800_0000) begin errors++; $display("FAIL srai_result got rv=%0b %h want 1 f8000000", result_valid_o, result_o); end
    handshake();
  endtask

  task automatic test_illegal_backpressure();
    issue(7'b1101111, 3'b000, 7'b0000000, 32'd9, 32'd9, 32'd9);
    checks++; if (ALUCtrl_o !== 3'b111) begin errors++; $display("FAIL ill_ctrl got %b want 111", ALUCtrl_o); end
    @(negedge clk_i);
    // Offer a new add while the illegal result is stalled downstream.
    set_op(7'b0110011, 3'b000, 7'b0000000, 32'd100, 32'd1, 32'd0);
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (result_valid_o !== 1'b1 || illegal_o !== 1'b1 || result_o !== 32'd0 ||
          ready_o !== 1'b0 || ALUin1_o !== 32'd9) begin
        errors++;
        $display("FAIL ill_hold cyc %0d got rv=%0b ill=%0b res=%h ready=%0b in1=%0d want 1/1/0/0/9",
                 i, result_valid_o, illegal_o, result_o, ready_o, ALUin1_o);
      end
      @(negedge clk_i);
    end
    // Handshake with valid_i still high: no accept on the handshake edge.
    handshake();
    checks++; if (ready_o !== 1'b1 || result_valid_o !== 1'b0 || ALUCtrl_o !== 3'b111 || ALUin1_o !== 32'd9) begin errors++; $display("FAIL ill_no_accept got ready=%0b rv=%0b ctrl=%b in1=%0d want 1/0/111/9", ready_o, result_valid_o, ALUCtrl_o, ALUin1_o); end
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    checks++; if (ALUCtrl_o !== 3'b010 || ALUin1_o !== 32'd100 || ready_o !== 1'b0) begin errors++; $display("FAIL ill_then_accept got ctrl=%b in1=%0d ready=%0b want 010/100/0", ALUCtrl_o, ALUin1_o, ready_o); end
    @(negedge clk_i);
    checks++; if (result_valid_o !== 1'b1 || result_o !== 32'd101 || illegal_o !== 1'b0) begin errors++; $display("FAIL ill_next_result got rv=%0b %0d ill=%0b want 1 101 0", result_valid_o, result_o, illegal_o); end
    handshake();
  endtask

  task automatic test_flush();
    logic seen_rv;
    issue(7'b0110011, 3'b000, 7'b0000001, 32'd3, 32'd4, 32'd0);
    flush_i = 1'b1;
    set_op(7'b0110011, 3'b000, 7'b0000000, 32'd55, 32'd1, 32'd0);
    valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b0;
    valid_i = 1'b0;
    checks++; if (ready_o !== 1'b1 || result_valid_o !== 1'b0 || ALUCtrl_o !== 3'b111 || illegal_o !== 1'b0) begin errors++; $display("FAIL flush_state got ready=%0b rv=%0b ctrl=%b ill=%0b want 1/0/111/0", ready_o, result_valid_o, ALUCtrl_o, illegal_o); end
    checks++; if (ALUin1_o !== 32'd3) begin errors++; $display("FAIL flush_no_accept got in1=%0d want 3", ALUin1_o); end
    seen_rv = 1'b0;
    repeat (5) begin
      if (result_valid_o !== 1'b0) seen_rv = 1'b1;
      @(negedge clk_i);
    end
    checks++; if (seen_rv !== 1'b0) begin errors++; $display("FAIL flush_rv_never got %0b want 0", seen_rv); end
    issue(7'b0110011, 3'b000, 7'b0000000, 32'd10, 32'd20, 32'd0);
    @(negedge clk_i);
    checks++; if (result_valid_o !== 1'b1 || result_o !== 32'd30) begin errors++; $display("FAIL flush_next_add got rv=%0b %0d want 1 30", result_valid_o, result_o); end
    handshake();
  endtask

  task automatic test_reset_mid();
    issue(7'b0110011, 3'b000, 7'b0000001, 32'd8, 32'd8, 32'd0);
    #1 rst_i = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b1 || ALUCtrl_o !== 3'b111 || ALUin1_o !== 32'd0 || result_o !== 32'd0) begin errors++; $display("FAIL reset_mid got ready=%0b ctrl=%b in1=%0d res=%0d want 1/111/0/0", ready_o, ALUCtrl_o, ALUin1_o, result_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (4) @(negedge clk_i);
    checks++; if (result_valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL reset_mid_discard got rv=%0b ready=%0b want 0/1", result_valid_o, ready_o); end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_i          = 1'b0;
    flush_i        = 1'b0;
    valid_i        = 1'b0;
    result_ready_i = 1'b0;
    set_op(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk_i);
    test_reset();
    test_add();
    test_mul();
    test_srai();
    test_illegal_backpressure();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
EX-stage sequencer that drives the ALU's operand/control interface (ALUin1, ALUin2, ALUCtrl) and captures ALUResult. It decodes the RV32I/M subset into the 3-bit ALU control code and holds operands stable for the required number of cycles, with MUL_LAT cycles for the multicycle-constrained multiplier. It then returns the result downstream through a valid/ready handshake. It sits between the ID/EX register and the EX/MEM register.

Parameters:
MUL_LAT, 2, cycles ALU inputs held stable for mul before capture (legal range 1..15)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
flush_i  in  1  synchronous pipeline flush
valid_i  in  1  upstream op valid
ready_o  out  1  block can accept an op
opcode_i  in  7  instruction opcode
funct3_i  in  3  instruction funct3
funct7_i  in  7  instruction funct7
rs1_data_i  in  32  source 1 value
rs2_data_i  in  32  source 2 value
imm_i  in  32  sign-extended immediate
ALUin1_o  out  32  to ALU operand 1
ALUin2_o  out  32  to ALU operand 2
ALUCtrl_o  out  3  to ALU control
ALUResult_i  in  32  from ALU (combinational)
result_o  out  32  captured result
illegal_o  out  1  op decoded to unsupported (valid with result_valid_o)
result_valid_o  out  1  result available
result_ready_i  in  1  downstream accepts result

Behaviour:
- Reset (rst_i low, async): state IDLE, ready_o=1, ALUin1_o=ALUin2_o=0, ALUCtrl_o=3'b111, result_o=0, illegal_o=0, result_valid_o=0, counter=0.
- ALU codes: 000 and, 001 xor, 010 add, 011 sub, 100 sll, 101 mul, 110 srai, 111 unsupported (ALU returns 0).
- Decode. Second operand is rs2 unless noted:
  - 0110011/f7=0000000: f3 111 and, 100 xor, 000 add, 001 sll.
  - 0110011/f7=0100000/f3 000: sub.
  - 0110011/f7=0000001/f3 000: mul.
  - 0010011/f3 000: add with imm (addi).
  - 0010011/f3 101/f7=0100000: srai with {27'b0, imm_i[4:0]}.
  - 0000011 (load) and 0100011 (store): add with imm.
  - 1100011 (branch): sub.
  - Anything else: 111, illegal flag set.
- ALUin1_o is always rs1_data_i latched.
- FSM IDLE -> EXEC -> DONE -> IDLE. ready_o = (state==IDLE).
  - IDLE: on valid_i&&ready_o, register ALUin1_o/ALUin2_o/ALUCtrl_o and illegal flag. Load counter = MUL_LAT-1 for mul, 0 otherwise. Go to EXEC.
  - EXEC: outputs to ALU held constant.
    - Counter != 0: decrement.
    - Counter == 0: result_o<=ALUResult_i, illegal_o<=flag, result_valid_o<=1, go to DONE.
  - DONE: hold result_o, illegal_o and result_valid_o. On result_ready_i, clear result_valid_o and return to IDLE. No new accept in the same cycle.
- Latency, accept edge N: non-mul result_valid_o high after edge N+1; mul after edge N+MUL_LAT. Throughput ≥3 cycles/op.
- ALU inputs stay at the last issued values in IDLE/DONE; they change only on accept.
- flush_i (sync) wins over every other event in any state: go to IDLE, result_valid_o=0, illegal_o=0, ALUCtrl_o=3'b111. A valid_i in the same cycle is not accepted.
- Reset mid-EXEC/DONE: immediate return to reset values; the in-flight op is discarded.
- Arithmetic is defined entirely by the ALU; this block only routes and captures 32-bit values, with no width changes except srai shamt zero-extension.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles -> ready_o=1, result_valid_o=0, ALUCtrl_o=3'b111, result_o=0.
- add: opcode 0110011/f7 0/f3 000, rs1=5, rs2=7 -> ALUCtrl_o=010 one cycle after accept; result_o=12 with result_valid_o=1 at N+1.
- mul with MUL_LAT=3: rs1=6, rs2=7 -> ALUCtrl_o=101 held 3 cycles; result_o=42 at N+3; ready_o=0 throughout.
- srai: opcode 0010011/f3 101/f7 0100000, rs1=0x80000000, imm=0x404 -> ALUin2_o=4, result_o=0xF8000000.
- Backpressure/illegal: opcode 1101111 with result_ready_i=0 for 4 cycles -> illegal_o=1 and result_o=0 held stable; valid_i ignored until the handshake completes.
- Flush: flush_i asserted during a mul EXEC -> next cycle in IDLE, result_valid_o never asserted for that op; next add op completes normally.
